ttt_board_ctrl: RTL and testbench

Move-entry and board-state controller for the tic-tac-toe datapath. It accepts player moves over a valid/ready handshake, writes the 9-cell occupancy (`valid`) and owner (`symbol`) vectors consumed by the win checker, alternates turns, and samples the checker's `game_state`. It latches the game result and drives the checker's `prev_game_state` and reset inputs, so the checker's latched result is cleared on every new game.

---
 rtl/ttt_board_ctrl.sv | 133 +++++++++++++
 tb/tb_ttt_board_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe move entry and board state: accepts moves, keeps occupancy/owner vectors,
// alternates turns, and latches the checker's result with an optional per-turn timeout.
module ttt_board_ctrl #(
  parameter int unsigned FIRST_PLAYER   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_ok,
  output logic       move_err,
  output logic       timeout,
  output logic       turn,
  output logic [8:0] valid,
  output logic [8:0] symbol,
  input  logic [1:0] game_state,
  output logic [1:0] prev_game_state,
  output logic       win_reset,
  output logic [3:0] move_count
);

  typedef enum logic [1:0] {S_CLEAR, S_PLAY, S_EVAL, S_OVER} state_t;

  localparam logic        FP     = (FIRST_PLAYER != 0);
  localparam logic        TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [8:0]  valid_q, valid_d;
  logic [8:0]  symbol_q, symbol_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  prev_q, prev_d;
  logic        turn_q, turn_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic [15:0] timer_q, timer_d;

  logic [15:0] occ;
  logic [8:0]  sel;
  logic        accept;

  // Positions 9..15 read as occupied so a single lookup rejects them too.
  assign occ    = {7'h7f, valid_q};
  assign sel    = 9'd1 << move_pos;
  assign accept = (state_q == S_PLAY) && move_valid && !occ[move_pos];

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    symbol_d = symbol_q;
    count_d  = count_q;
    prev_d   = prev_q;
    turn_d   = turn_q;
    timer_d  = timer_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      S_CLEAR: state_d = S_PLAY;
      S_PLAY: begin
        if (accept) begin
          valid_d  = valid_q | sel;
          symbol_d = turn_q ? (symbol_q | sel) : (symbol_q & ~sel);
          count_d  = count_q + 4'd1;
          ok_d     = 1'b1;
          state_d  = S_EVAL;
        end else if (TO_EN && timer_q == TO_MAX) begin
          // A forfeit takes precedence over reporting a bad move in the same cycle.
          to_d    = 1'b1;
          turn_d  = ~turn_q;
          timer_d = '0;
        end else begin
          err_d = move_valid;
          if (TO_EN) timer_d = timer_q + 16'd1;
        end
      end
      S_EVAL: begin
        if (game_state != 2'b00) begin
          prev_d  = game_state;
          state_d = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          timer_d = '0;
          state_d = S_PLAY;
        end
      end
      S_OVER: err_d = move_valid;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state_q  <= S_CLEAR;
      valid_q  <= '0;
      symbol_q <= '0;
      count_q  <= '0;
      prev_q   <= '0;
      turn_q   <= FP;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      symbol_q <= symbol_d;
      count_q  <= count_d;
      prev_q   <= prev_d;
      turn_q   <= turn_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      to_q     <= to_d;
      timer_q  <= timer_d;
    end
  end

  assign move_ready      = (state_q == S_PLAY);
  assign win_reset       = (state_q == S_CLEAR);
  assign move_ok         = ok_q;
  assign move_err        = err_q;
  assign timeout         = to_q;
  assign turn            = turn_q;
  assign valid           = valid_q;
  assign symbol          = symbol_q;
  assign prev_game_state = prev_q;
  assign move_count      = count_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Bench for ttt_board_ctrl: directed game scenarios plus random traffic against a board-level model.
module tb_ttt_board_ctrl;

  localparam int TO = 8;
  localparam int PH_CLEAR = 0, PH_PLAY = 1, PH_EVAL = 2, PH_OVER = 3;
  localparam int LINES [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

  logic       clk = 1'b0;
  logic       reset = 1'b1, new_game = 1'b0, move_valid = 1'b0;
  logic [3:0] move_pos = '0;
  logic       move_ready, move_ok, move_err, timeout, turn, win_reset;
  logic [8:0] valid, symbol;
  logic [1:0] game_state, prev_game_state;
  logic [3:0] move_count;

  int errors = 0;
  int checks = 0;

  // Model state: board as occupancy/owner sets, game phase, turn, counters.
  int         m_phase;
  logic [8:0] m_v, m_s;
  logic       m_turn;
  int         m_count, m_timer;
  logic [1:0] m_prev;
  logic       m_ok, m_err, m_to;

  always #5 clk = ~clk;

  function automatic logic [1:0] judge(input logic [8:0] v, input logic [8:0] s);
    for (int k = 0; k < 8; k++) begin
      int a, b, c;
      a = LINES[3*k]; b = LINES[3*k+1]; c = LINES[3*k+2];
      if (v[a] && v[b] && v[c] && s[a] == s[b] && s[b] == s[c])
        return s[a] ? 2'b01 : 2'b10;
    end
    if (v == 9'h1FF) return 2'b11;
    return 2'b00;
  endfunction

  // Stand-in for the win checker, looking at the board the controller publishes.
  assign game_state = judge(valid, symbol);

  ttt_board_ctrl #(.FIRST_PLAYER(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .move_valid(move_valid), .move_pos(move_pos), .move_ready(move_ready),
    .move_ok(move_ok), .move_err(move_err), .timeout(timeout), .turn(turn),
    .valid(valid), .symbol(symbol), .game_state(game_state),
    .prev_game_state(prev_game_state), .win_reset(win_reset), .move_count(move_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic ng, input logic mv, input logic [3:0] pos);
    int p;
    p = int'(pos);
    if (r || ng) begin
      m_phase = PH_CLEAR; m_v = '0; m_s = '0; m_count = 0; m_prev = 2'b00;
      m_turn = 1'b1; m_ok = 0; m_err = 0; m_to = 0; m_timer = 0;
      return;
    end
    m_ok = 0; m_err = 0; m_to = 0;
    case (m_phase)
      PH_CLEAR: m_phase = PH_PLAY;
      PH_PLAY: begin
        if (mv && p <= 8 && !m_v[p]) begin
          m_v[p] = 1'b1; m_s[p] = m_turn; m_count++; m_ok = 1; m_phase = PH_EVAL;
        end else if (m_timer == TO - 1) begin
          m_to = 1; m_turn = ~m_turn; m_timer = 0;
        end else begin
          m_err = mv; m_timer++;
        end
      end
      PH_EVAL: begin
        if (judge(m_v, m_s) != 2'b00) begin
          m_prev = judge(m_v, m_s); m_phase = PH_OVER;
        end else begin
          m_turn = ~m_turn; m_timer = 0; m_phase = PH_PLAY;
        end
      end
      default: m_err = mv;
    endcase
  endtask

  task automatic compare_all();
    check("move_ready", move_ready, m_phase == PH_PLAY);
    check("win_reset", win_reset, m_phase == PH_CLEAR);
    check("move_ok", move_ok, m_ok);
    check("move_err", move_err, m_err);
    check("timeout", timeout, m_to);
    check("turn", turn, m_turn);
    check("valid", valid, m_v);
    check("symbol", symbol, m_s);
    check("move_count", move_count, m_count);
    check("prev_game_state", prev_game_state, m_prev);
  endtask

  task automatic step(input logic r, input logic ng, input logic mv, input logic [3:0] pos);
    @(negedge clk);
    reset = r; new_game = ng; move_valid = mv; move_pos = pos;
    @(posedge clk);
    model_edge(r, ng, mv, pos);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic move(input logic [3:0] pos);
    int n;
    n = 0;
    while (m_phase != PH_PLAY && n < 4) begin
      idle();
      n++;
    end
    check("reach_play", m_phase == PH_PLAY, 1);
    step(1'b0, 1'b0, 1'b1, pos);
    idle();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    // Reset values and the single CLEAR cycle.
    do_reset();
    check("rst_win_reset", win_reset, 1);
    check("rst_turn", turn, 1);
    check("rst_valid", valid, 0);
    idle();
    check("play_ready", move_ready, 1);

    // Player 1 top-row win.
    move(4'd0); move(4'd3); move(4'd1); move(4'd4); move(4'd2);
    check("row_prev", prev_game_state, 2'b01);
    check("row_count", move_count, 5);
    check("row_valid", valid, 9'h01F);
    check("row_ready", move_ready, 0);

    // Draw: result appears only after the ninth move.
    do_reset();
    move(4'd0); move(4'd1); move(4'd2); move(4'd4);
    move(4'd3); move(4'd5); move(4'd7); move(4'd6);
    check("draw_prev8", prev_game_state, 2'b00);
    move(4'd8);
    check("draw_prev", prev_game_state, 2'b11);
    check("draw_count", move_count, 9);
    check("draw_valid", valid, 9'h1FF);

    // Occupied and out-of-range positions.
    do_reset();
    move(4'd4);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    check("occ_err", move_err, 1);
    check("occ_turn", turn, 0);
    step(1'b0, 1'b0, 1'b1, 4'd9);
    check("pos9_err", move_err, 1);
    step(1'b0, 1'b0, 1'b1, 4'd15);
    check("pos15_err", move_err, 1);
    check("bad_valid", valid, 9'h010);

    // Timeout after eight idle PLAY cycles, then an accept on the eighth cycle.
    do_reset();
    idle();
    for (int i = 0; i < 7; i++) idle();
    check("to_none_yet", timeout, 0);
    idle();
    check("to_pulse", timeout, 1);
    check("to_turn", turn, 0);
    for (int i = 0; i < 7; i++) idle();
    step(1'b0, 1'b0, 1'b1, 4'd2);
    check("to_accept_ok", move_ok, 1);
    check("to_accept_no_to", timeout, 0);
    idle();

    // New game collides with a move.
    do_reset();
    move(4'd0); move(4'd1); move(4'd2);
    step(1'b0, 1'b1, 1'b1, 4'd5);
    check("ng_ok", move_ok, 0);
    check("ng_valid", valid, 0);
    check("ng_win_reset", win_reset, 1);
    check("ng_turn", turn, 1);
    idle();
    check("ng_win_reset_low", win_reset, 0);

    // Player 2 column win, then moves are refused until reset.
    do_reset();
    move(4'd0); move(4'd1); move(4'd2); move(4'd4); move(4'd8); move(4'd7);
    check("col_prev", prev_game_state, 2'b10);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    check("over_err", move_err, 1);
    check("over_valid", valid, 9'h197);
    do_reset();
    check("post_rst_prev", prev_game_state, 0);
    check("post_rst_count", move_count, 0);
    check("post_rst_symbol", symbol, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic r, ng, mv;
      logic [3:0] pos;
      r   = ($urandom_range(0, 199) == 0);
      ng  = ($urandom_range(0, 59) == 0);
      mv  = ($urandom_range(0, 2) != 0);
      pos = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      step(r, ng, mv, pos);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
